// File: rtl/lcd_mmio_ctrl.sv
// lcd_mmio_ctrl: memory-mapped HD44780 LCD controller with a write FIFO and a timed E-strobe sequencer
module lcd_mmio_ctrl #(
    parameter int DEPTH        = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int CMD_WAIT     = 100,
    parameter int DATA_WAIT    = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_sel,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wenable,
    output logic [31:0] bus_rdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_enable
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int M1   = SETUP_CYCLES > PULSE_CYCLES ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int M2   = M1 > HOLD_CYCLES ? M1 : HOLD_CYCLES;
    localparam int M3   = M2 > CMD_WAIT ? M2 : CMD_WAIT;
    localparam int MAXC = M3 > DATA_WAIT ? M3 : DATA_WAIT;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

    logic [8:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            en_q, en_d, rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            wr, push_req, push, pop, ctrl, flush, empty, full, expire;
    logic [8:0]      head;
    logic            unused;

    assign wr       = bus_sel & bus_wenable[0];
    assign push_req = wr & ~bus_addr[1];
    assign ctrl     = wr & (bus_addr == 2'd3);
    assign flush    = ctrl & bus_wdata[1];
    assign empty    = count_q == '0;
    assign full     = count_q == CNTW'(DEPTH);
    assign pop      = (state_q == S_IDLE) & ~empty;
    // a full FIFO still accepts a push when the sequencer frees a slot on the same edge
    assign push     = push_req & (~full | pop);
    assign head     = mem_q[rptr_q];
    assign expire   = cnt_q == CW'(1);
    assign unused   = &{1'b0, bus_wdata[31:8], bus_wenable[3:1]};

    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_enable = en_q;

    // status register decode; everything except STATUS reads as zero
    always_comb begin
        bus_rdata = (bus_sel && bus_addr == 2'd2)
                  ? {16'h0, 8'(count_q), 4'h0, ovf_q, state_q != S_IDLE, full, empty}
                  : 32'h0;
    end

    // FIFO pointers, occupancy and sticky overflow; flush drops queued entries only
    always_comb begin
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = flush ? wptr_q : rptr_q + AW'(pop);
        count_d = flush ? '0 : count_q + CNTW'(push) - CNTW'(pop);
        ovf_d   = (ctrl & bus_wdata[0]) ? 1'b0 : (ovf_q | (push_req & ~push));
    end

    // sequencer: pop, then setup/pulse/hold/wait, each lasting its programmed cycle count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CW'(1);
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (pop) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYCLES);
                    rs_d    = head[8];
                    data_d  = head[7:0];
                end
            end
            S_SETUP: if (expire) begin
                state_d = S_PULSE;
                cnt_d   = CW'(PULSE_CYCLES);
                en_d    = 1'b1;
            end
            S_PULSE: if (expire) begin
                state_d = S_HOLD;
                cnt_d   = CW'(HOLD_CYCLES);
                en_d    = 1'b0;
            end
            S_HOLD: if (expire) begin
                state_d = S_WAIT;
                cnt_d   = rs_q ? CW'(DATA_WAIT) : CW'(CMD_WAIT);
            end
            S_WAIT: if (expire) state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {~bus_addr[0], bus_wdata[7:0]};
    end

    // state registers; reset aborts any transfer and empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_lcd_mmio_ctrl.sv
// tb_lcd_mmio_ctrl: register table, LCD pulse scoreboard and timing sequences for lcd_mmio_ctrl
module tb_lcd_mmio_ctrl;
    localparam int PULSE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_sel = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic [3:0]  bus_wenable = 4'd0;
    logic [31:0] bus_rdata;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_enable;

    int         n_chk = 0;
    int         n_pass = 0;
    int         n_pulse = 0;
    int         hi_len = 0;
    logic       prev_en = 1'b0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic        wsel;
        logic [1:0]  waddr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        rsel;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    lcd_mmio_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wenable(bus_wenable), .bus_rdata(bus_rdata),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_enable(lcd_enable)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_sel = 1'b1;
        bus_addr = a;
        bus_wdata = d;
        bus_wenable = 4'h1;
        @(posedge clk);
        #1;
        bus_sel = 1'b0;
        bus_wenable = 4'h0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus_sel = 1'b1;
        bus_wenable = 4'h0;
        bus_addr = a;
        #1;
        v = bus_rdata;
        bus_sel = 1'b0;
    endtask

    task automatic wait_status(input logic [31:0] exp, input int max, input string name);
        logic [31:0] v;
        rd(2'd2, v);
        for (int i = 0; i < max && v !== exp; i++) begin
            @(posedge clk);
            #1;
            rd(2'd2, v);
        end
        chk(name, v, exp);
    endtask

    task automatic wait_enable(input string name);
        for (int i = 0; i < 20 && !lcd_enable; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, {31'd0, lcd_enable}, 32'd1);
    endtask

    // scoreboard: each rising E must match the oldest accepted write; each pulse must last PULSE cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en <= 1'b0;
            hi_len <= 0;
        end else begin
            if (lcd_enable && !prev_en) begin
                n_pulse <= n_pulse + 1;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL pulse_unexpected: got rs=%0b data=0x%02h expected no pulse", lcd_rs, lcd_data);
                end else chk("pulse_rs_data", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_q.pop_front()});
            end
            if (!lcd_enable && prev_en) chk("pulse_width", 32'(hi_len), 32'(PULSE));
            hi_len <= lcd_enable ? hi_len + 1 : 0;
            prev_en <= lcd_enable;
        end
    end

    initial begin
        vec_t        vecs[9];
        logic [31:0] v;
        int          cnt;
        int          p;
        vecs[0] = '{1'b0, 2'd0, 4'h0, 32'h0,        1'b1, 2'd2, 32'h1};
        vecs[1] = '{1'b0, 2'd0, 4'h0, 32'h0,        1'b1, 2'd0, 32'h0};
        vecs[2] = '{1'b0, 2'd0, 4'h0, 32'h0,        1'b1, 2'd1, 32'h0};
        vecs[3] = '{1'b0, 2'd0, 4'h0, 32'h0,        1'b1, 2'd3, 32'h0};
        vecs[4] = '{1'b0, 2'd0, 4'h0, 32'h0,        1'b0, 2'd2, 32'h0};
        vecs[5] = '{1'b1, 2'd2, 4'hF, 32'hFFFFFFFF, 1'b1, 2'd2, 32'h1};
        vecs[6] = '{1'b1, 2'd0, 4'hE, 32'h12,       1'b1, 2'd2, 32'h1};
        vecs[7] = '{1'b0, 2'd1, 4'h1, 32'h12,       1'b1, 2'd2, 32'h1};
        vecs[8] = '{1'b1, 2'd3, 4'h1, 32'h3,        1'b1, 2'd2, 32'h1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_enable", {31'd0, lcd_enable}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_data", {24'd0, lcd_data}, 32'd0);
        rst_n = 1'b1;
        chk("rst_rw", {31'd0, lcd_rw}, 32'd0);

        foreach (vecs[i]) begin
            bus_sel = vecs[i].wsel;
            bus_addr = vecs[i].waddr;
            bus_wenable = vecs[i].wen;
            bus_wdata = vecs[i].wdata;
            @(posedge clk);
            #1;
            bus_wenable = 4'h0;
            bus_sel = vecs[i].rsel;
            bus_addr = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d", i), bus_rdata, vecs[i].exp);
            bus_sel = 1'b0;
        end

        // single command: latch next cycle, E high 2 cycles later for 4, busy 109 cycles
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 8'h38});
        wr(2'd1, 32'h38);
        @(posedge clk);
        #1;
        chk("cmd_rs", {31'd0, lcd_rs}, 32'd0);
        chk("cmd_data", {24'd0, lcd_data}, 32'h38);
        chk("cmd_setup_en0", {31'd0, lcd_enable}, 32'd0);
        @(posedge clk);
        #1;
        chk("cmd_setup_en1", {31'd0, lcd_enable}, 32'd0);
        @(posedge clk);
        #1;
        chk("cmd_en_rise", {31'd0, lcd_enable}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("cmd_en_last", {31'd0, lcd_enable}, 32'd1);
        @(posedge clk);
        #1;
        chk("cmd_en_fall", {31'd0, lcd_enable}, 32'd0);
        repeat (101) @(posedge clk);
        #1;
        rd(2'd2, v);
        chk("cmd_busy_end", v, 32'h5);
        @(posedge clk);
        #1;
        rd(2'd2, v);
        chk("cmd_idle", v, 32'h1);

        // two data bytes back to back: second latch 49 cycles after the first
        exp_q.push_back({1'b1, 8'h48});
        exp_q.push_back({1'b1, 8'h69});
        wr(2'd0, 32'h48);
        wr(2'd0, 32'h69);
        rd(2'd2, v);
        chk("hi_midstream", v, 32'h0104);
        chk("hi_first", {23'd0, lcd_rs, lcd_data}, 32'h148);
        cnt = 0;
        while (lcd_data !== 8'h69 && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("hi_gap", 32'(cnt), 32'd49);
        wait_status(32'h1, 200, "hi_drain");

        // overflow while the sequencer sits in a command wait
        exp_q.push_back({1'b0, 8'h01});
        wr(2'd1, 32'h01);
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back({1'b1, 8'(8'h30 + i)});
            wr(2'd0, 32'h30 + 32'(i));
        end
        rd(2'd2, v);
        chk("ovf_status", v, 32'h080E);
        wr(2'd3, 32'h1);
        rd(2'd2, v);
        chk("ovf_clear", v, 32'h0806);
        wait_status(32'h1, 1000, "ovf_drain");
        chk("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

        // flush during a pulse: in-flight entry completes, queued ones vanish
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b1, 8'(8'h41 + i)});
            wr(2'd0, 32'h41 + 32'(i));
        end
        wait_enable("flush_wait_en");
        wr(2'd3, 32'h2);
        exp_q.delete();
        rd(2'd2, v);
        chk("flush_status", v, 32'h5);
        chk("flush_pulse_alive", {31'd0, lcd_enable}, 32'd1);
        p = n_pulse;
        wait_status(32'h1, 300, "flush_idle");
        repeat (100) @(posedge clk);
        #1;
        chk("flush_no_pulse", 32'(n_pulse), 32'(p));

        // reset during a pulse drops E without waiting for a clock
        exp_q.push_back({1'b1, 8'h55});
        wr(2'd0, 32'h55);
        wait_enable("rst_wait_en");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_en", {31'd0, lcd_enable}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(2'd2, v);
        chk("rst_status", v, 32'h1);
        chk("rst_pins", {23'd0, lcd_rs, lcd_data}, 32'd0);
        p = n_pulse;
        repeat (150) @(posedge clk);
        #1;
        chk("rst_no_pulse", 32'(n_pulse), 32'(p));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
